icache_ctrl: RTL

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl_pkg.sv | 24 ++
 rtl/icache_ctrl_if.sv | 30 +++
 rtl/icache_array.sv | 81 ++++++++
 rtl/icache_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller:
// bus widths, FSM state encoding and a line-address helper.
package icache_ctrl_pkg;

  localparam int AddrBus = 64;
  localparam int DataBus = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_DATA,
    RESP
  } state_e;

  // Clears the byte-within-line bits so the refill always starts at beat 0.
  function automatic logic [AddrBus-1:0] line_base(input logic [AddrBus-1:0] addr,
                                                   input int unsigned line_bytes_log2);
    logic [AddrBus-1:0] mask;
    mask = {AddrBus{1'b1}} << line_bytes_log2;
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Core-side fetch port, invalidate pulse and memory-side refill port of the cache.
// The slave modport is the cache view; master is the core/memory environment view.
interface icache_ctrl_if;
  import icache_ctrl_pkg::*;

  logic               icache_req_valid_i;
  logic [AddrBus-1:0] icache_addr_i;
  logic               icache_data_valid_o;
  logic [DataBus-1:0] icache_data_o;
  logic               fence_i_i;

  logic               mem_req_valid_o;
  logic               mem_req_ready_i;
  logic [AddrBus-1:0] mem_addr_o;
  logic               mem_resp_valid_i;
  logic [DataBus-1:0] mem_resp_data_i;

  modport slave (
    input  icache_req_valid_i, icache_addr_i, fence_i_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    output icache_data_valid_o, icache_data_o, mem_req_valid_o, mem_addr_o
  );

  modport master (
    output icache_req_valid_i, icache_addr_i, fence_i_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    input  icache_data_valid_o, icache_data_o, mem_req_valid_o, mem_addr_o
  );

endinterface

// File: rtl/icache_array.sv
// Data RAM (LINES x LINE_BEATS beats) plus tag/valid store with one synchronous
// read port and one beat write port; a same-cycle write is forwarded to the read.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_BEATS = 4,
  parameter int TAG_W      = 53
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(LINES)-1:0]      rd_idx,
  input  logic [$clog2(LINE_BEATS)-1:0] rd_beat,
  output logic [DataBus-1:0]            rd_data_o,
  output logic [TAG_W-1:0]              rd_tag_o,
  output logic                          rd_valid_o,
  input  logic                          wr_en,
  input  logic [$clog2(LINES)-1:0]      wr_idx,
  input  logic [$clog2(LINE_BEATS)-1:0] wr_beat,
  input  logic [DataBus-1:0]            wr_data,
  input  logic                          tag_we,
  input  logic                          tag_valid,
  input  logic [TAG_W-1:0]              tag_wdata,
  input  logic                          inval_all
);

  logic [DataBus-1:0] data_mem [LINES*LINE_BEATS];
  logic [TAG_W-1:0]   tag_mem  [LINES];

  logic [LINES-1:0]   valid_q, valid_d;
  logic [DataBus-1:0] rd_data_q, rd_data_d;
  logic [TAG_W-1:0]   rd_tag_q, rd_tag_d;
  logic               rd_valid_q, rd_valid_d;

  // Invalidate-all wins over a concurrent line fill.
  always_comb begin
    valid_d = valid_q;
    if (inval_all) begin
      valid_d = '0;
    end else if (tag_we) begin
      valid_d[wr_idx] = tag_valid;
    end
    rd_valid_d = valid_d[rd_idx];
    rd_data_d  = data_mem[{rd_idx, rd_beat}];
    rd_tag_d   = tag_mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx) && (wr_beat == rd_beat)) begin
      rd_data_d = wr_data;
    end
    if (tag_we && (wr_idx == rd_idx)) begin
      rd_tag_d = tag_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_tag_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      data_mem[{wr_idx, wr_beat}] <= wr_data;
    end
    if (tag_we && !rst) begin
      tag_mem[wr_idx] <= tag_wdata;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 2-cycle hits, line refill on miss.
// Define ICACHE_STATS_EN to add saturating hit/miss counters (stat_hit_o, stat_miss_o).
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  icache_ctrl_if.slave      bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [63:0]       stat_hit_o,
  output logic [63:0]       stat_miss_o
`endif
);

  localparam int BeatW  = $clog2(LINE_BEATS);
  localparam int IdxW   = $clog2(LINES);
  localparam int IdxLsb = 3 + BeatW;
  localparam int TagLsb = IdxLsb + IdxW;
  localparam int TagW   = AddrBus - TagLsb;

  state_e             state_q, state_d;
  logic [AddrBus-1:0] addr_q, addr_d;
  logic [BeatW-1:0]   beat_cnt_q, beat_cnt_d;
  logic               fence_pend_q, fence_pend_d;
  logic               data_valid_q, data_valid_d;
  logic [DataBus-1:0] data_q, data_d;

  logic [AddrBus-1:0] rd_addr;
  logic [DataBus-1:0] rd_data;
  logic [TagW-1:0]    rd_tag;
  logic               rd_valid;
  logic               hit;
  logic [DataBus-1:0] word;
  logic               wr_en, tag_we, tag_valid;

  // In IDLE the array is addressed straight from the core so the tag is ready in LOOKUP.
  assign rd_addr = (state_q == IDLE) ? bus.icache_addr_i : addr_q;
  assign hit     = rd_valid && (rd_tag == addr_q[TagLsb +: TagW]);
  assign word    = addr_q[2] ? {32'b0, rd_data[63:32]} : {32'b0, rd_data[31:0]};

  icache_array #(
    .LINES      (LINES),
    .LINE_BEATS (LINE_BEATS),
    .TAG_W      (TagW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (rd_addr[IdxLsb +: IdxW]),
    .rd_beat    (rd_addr[3 +: BeatW]),
    .rd_data_o  (rd_data),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .wr_en      (wr_en),
    .wr_idx     (addr_q[IdxLsb +: IdxW]),
    .wr_beat    (beat_cnt_q),
    .wr_data    (bus.mem_resp_data_i),
    .tag_we     (tag_we),
    .tag_valid  (tag_valid),
    .tag_wdata  (addr_q[TagLsb +: TagW]),
    .inval_all  (bus.fence_i_i)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    fence_pend_d = fence_pend_q;
    data_valid_d = 1'b0;
    data_d       = data_q;
    wr_en        = 1'b0;
    tag_we       = 1'b0;
    tag_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        fence_pend_d = 1'b0;
        // The core still holds its request during the response cycle; don't replay it.
        if (bus.icache_req_valid_i && !data_valid_q) begin
          addr_d  = bus.icache_addr_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_valid_d = 1'b1;
          data_d       = word;
          state_d      = IDLE;
        end else begin
          state_d = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        if (bus.fence_i_i) fence_pend_d = 1'b1;
        if (bus.mem_req_ready_i) state_d = REFILL_DATA;
      end
      REFILL_DATA: begin
        if (bus.fence_i_i) fence_pend_d = 1'b1;
        if (bus.mem_resp_valid_i) begin
          wr_en      = 1'b1;
          beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (beat_cnt_q == BeatW'(LINE_BEATS - 1)) begin
            tag_we    = 1'b1;
            tag_valid = !(fence_pend_q || bus.fence_i_i);
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        data_valid_d = 1'b1;
        data_d       = word;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      fence_pend_q <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      fence_pend_q <= fence_pend_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
    end
  end

  assign bus.icache_data_valid_o = data_valid_q;
  assign bus.icache_data_o       = data_q;
  assign bus.mem_req_valid_o     = (state_q == REFILL_REQ);
  assign bus.mem_addr_o          = line_base(addr_q, 3 + BeatW);

`ifdef ICACHE_STATS_EN
  logic [63:0] stat_hit_q, stat_hit_d, stat_miss_q, stat_miss_d;

  always_comb begin
    stat_hit_d  = stat_hit_q;
    stat_miss_d = stat_miss_q;
    if (state_q == LOOKUP) begin
      if (hit && !(&stat_hit_q))   stat_hit_d  = stat_hit_q + 64'd1;
      if (!hit && !(&stat_miss_q)) stat_miss_d = stat_miss_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else begin
      stat_hit_q  <= stat_hit_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_hit_o  = stat_hit_q;
  assign stat_miss_o = stat_miss_q;
`endif

endmodule
